// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: parses SPI command frames and sequences word reads/writes on the register bus, streaming read data back as tx bytes.
module spi_cmd_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_clr_n,
    input  logic              i_cs_act,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    output logic              o_bus_wr,
    output logic              o_bus_rd,
    input  logic              i_bus_wait,
    input  logic [DATA_W-1:0] i_bus_rdata,
    input  logic              i_bus_rvalid,
    output logic              o_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TW    = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_CNT, S_WDATA, S_WBUS, S_RBUS, S_RWAIT, S_RSEND, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [BW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              rd_op_q, rd_op_d;
    logic              abort_q, abort_d;
    logic              err_q, err_d;
    logic              rx_take, tx_take, last_byte, last_word;

    assign o_rx_ready  = i_cs_act && (state_q != S_WBUS);
    assign o_tx_valid  = (state_q == S_RSEND);
    assign o_tx_data   = rdata_q[8*idx_q +: 8];
    assign o_bus_wr    = (state_q == S_WBUS);
    assign o_bus_rd    = (state_q == S_RBUS);
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = wdata_q;
    assign o_err       = err_q;

    assign rx_take   = o_rx_ready && i_rx_valid;
    assign tx_take   = o_tx_valid && i_tx_ready;
    assign last_byte = (idx_q == BW'(BYTES - 1));
    assign last_word = (cnt_q == 9'd1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        rd_op_d = rd_op_q;
        abort_d = abort_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: if (rx_take) begin
                rd_op_d = (i_rx_data == 8'h02);
                if (i_rx_data == 8'h01 || i_rx_data == 8'h02) state_d = S_ADDR;
                else if (i_rx_data != 8'h00) begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_ADDR: if (rx_take) begin
                addr_d  = ADDR_W'(i_rx_data);
                state_d = S_CNT;
            end
            S_CNT: if (rx_take) begin
                cnt_d   = {(i_rx_data == 8'h00), i_rx_data};
                idx_d   = '0;
                state_d = rd_op_q ? S_RBUS : S_WDATA;
            end
            S_WDATA: if (rx_take) begin
                wdata_d[8*idx_q +: 8] = i_rx_data;
                idx_d   = last_byte ? '0 : idx_q + 1'b1;
                state_d = last_byte ? S_WBUS : S_WDATA;
            end
            // an aborted request must still complete its bus handshake before IDLE
            S_WBUS: begin
                abort_d = abort_q || !i_cs_act;
                if (!i_bus_wait) begin
                    abort_d = 1'b0;
                    if (abort_q || !i_cs_act || last_word) state_d = S_IDLE;
                    else begin
                        cnt_d   = cnt_q - 9'd1;
                        addr_d  = addr_q + 1'b1;
                        state_d = S_WDATA;
                    end
                end
            end
            S_RBUS: begin
                abort_d = abort_q || !i_cs_act;
                if (!i_bus_wait) begin
                    abort_d = 1'b0;
                    tmo_d   = '0;
                    state_d = (abort_q || !i_cs_act) ? S_IDLE : S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (i_bus_rvalid) begin
                    rdata_d = i_bus_rdata;
                    idx_d   = '0;
                    state_d = S_RSEND;
                end else if (tmo_q == TW'(RD_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end else tmo_d = tmo_q + 1'b1;
            end
            S_RSEND: if (tx_take) begin
                idx_d = last_byte ? '0 : idx_q + 1'b1;
                if (last_byte) begin
                    if (last_word) state_d = S_IDLE;
                    else begin
                        cnt_d   = cnt_q - 9'd1;
                        addr_d  = addr_q + 1'b1;
                        state_d = S_RBUS;
                    end
                end
            end
            default: ;
        endcase
        if (!i_cs_act && state_q != S_WBUS && state_q != S_RBUS) begin
            state_d = S_IDLE;
            idx_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            rd_op_q <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            rd_op_q <= rd_op_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: scoreboard bench driving SPI byte frames and a bus/tx responder model.
module tb_spi_cmd_sequencer;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int RD_TIMEOUT = 255;

    logic              i_clk = 1'b0, i_clr_n = 1'b0, i_cs_act = 1'b0;
    logic [7:0]        i_rx_data = '0;
    logic              i_rx_valid = 1'b0, i_tx_ready = 1'b1;
    logic              i_bus_wait = 1'b0, i_bus_rvalid = 1'b0;
    logic [DATA_W-1:0] i_bus_rdata = '0;
    logic              o_rx_ready, o_tx_valid, o_bus_wr, o_bus_rd, o_err;
    logic [7:0]        o_tx_data;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [DATA_W-1:0] o_bus_wdata;

    spi_cmd_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .i_clk(i_clk), .i_clr_n(i_clr_n), .i_cs_act(i_cs_act),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_wr(o_bus_wr),
        .o_bus_rd(o_bus_rd), .i_bus_wait(i_bus_wait), .i_bus_rdata(i_bus_rdata),
        .i_bus_rvalid(i_bus_rvalid), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0, checks = 0;
    logic [ADDR_W+DATA_W-1:0] exp_wr[$];
    logic [ADDR_W-1:0]        exp_rd[$];
    logic [7:0]               exp_tx[$];
    logic [DATA_W-1:0]        rd_words[$];
    logic [DATA_W-1:0]        wdat[256];
    logic [ADDR_W+DATA_W-1:0] e;
    int  wait_cycles = 0, wcnt = 0, rv_delay = 3, rv_pend = 0, stall_next = 0, stall = 0;
    int  cyc = 0, wr_run = 0, rd_acc_cyc = 0, err_cyc = 0, err_cnt = 0, wr_total = 0;
    int  e0, t0, d;
    bit  rv_push = 1'b1, wr_acc, rd_acc, tx_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // monitor samples at negedge; responder updates bus/tx inputs just after posedge
    initial forever begin
        @(negedge i_clk);
        cyc++;
        wr_acc = o_bus_wr && !i_bus_wait;
        rd_acc = o_bus_rd && !i_bus_wait;
        tx_acc = o_tx_valid && i_tx_ready;
        wr_run = o_bus_wr ? wr_run + 1 : 0;
        if (o_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (wr_acc) begin
            wr_total++;
            chk("wr_hold", wr_run, wait_cycles + 1);
            if (exp_wr.size() == 0) chk("wr_unexp", exp_wr.size(), 1);
            else begin
                e = exp_wr.pop_front();
                chk("wr_addr", o_bus_addr, e[ADDR_W+DATA_W-1:DATA_W]);
                chk("wr_data", o_bus_wdata, e[DATA_W-1:0]);
            end
        end
        if (rd_acc) begin
            rd_acc_cyc = cyc;
            if (exp_rd.size() == 0) chk("rd_unexp", exp_rd.size(), 1);
            else chk("rd_addr", o_bus_addr, exp_rd.pop_front());
        end
        if (o_tx_valid) begin
            if (exp_tx.size() == 0) chk("tx_unexp", exp_tx.size(), 1);
            else begin
                chk("tx_data", o_tx_data, exp_tx[0]);
                if (tx_acc) void'(exp_tx.pop_front());
            end
        end
        @(posedge i_clk);
        #1;
        if (rd_acc) rv_pend = rv_delay;
        i_bus_rvalid = 1'b0;
        if (rv_pend > 0) begin
            rv_pend--;
            if (rv_pend == 0 && rd_words.size() > 0) begin
                i_bus_rdata  = rd_words.pop_front();
                i_bus_rvalid = 1'b1;
                if (rv_push) for (int i = 0; i < DATA_W / 8; i++) exp_tx.push_back(i_bus_rdata[8*i +: 8]);
                stall = (stall_next > 0) ? stall_next + 1 : 0;
            end
        end
        i_tx_ready = (stall == 0);
        if (stall > 0) stall--;
        if (o_bus_wr || o_bus_rd) begin
            i_bus_wait = (wcnt < wait_cycles);
            if (i_bus_wait) wcnt++;
        end else begin
            i_bus_wait = 1'b0;
            wcnt = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge i_clk);
            ok = o_rx_ready;
            @(posedge i_clk);
            #1;
        end
        i_rx_valid = 1'b0;
        if (!ok) chk("rx_hs", ok, 1);
    endtask

    task automatic start_frame();
        i_cs_act = 1'b1;
        tick(1);
    endtask

    task automatic end_frame();
        i_cs_act = 1'b0;
        tick(2);
    endtask

    task automatic write_frame(input logic [7:0] a, input logic [7:0] c);
        int n = (c == 0) ? 256 : int'(c);
        send_byte(8'h01);
        send_byte(a);
        send_byte(c);
        for (int w = 0; w < n; w++) begin
            exp_wr.push_back({a + 8'(w), wdat[w]});
            for (int i = 0; i < 4; i++) send_byte(wdat[w][8*i +: 8]);
            if (w == 0) chk("wr_lat", o_bus_wr, 1);
        end
    endtask

    task automatic read_frame(input logic [7:0] a, input logic [7:0] c);
        int n = (c == 0) ? 256 : int'(c);
        for (int w = 0; w < n; w++) exp_rd.push_back(a + 8'(w));
        send_byte(8'h02);
        send_byte(a);
        send_byte(c);
        chk("rd_lat", o_bus_rd, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_wr.size() > 0 || exp_rd.size() > 0 || exp_tx.size() > 0 || rd_words.size() > 0 || rv_pend > 0) && n < 5000) begin
            tick(1);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", n, 0);
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_rx_ready", o_rx_ready, 0);
        chk("rst_tx_valid", o_tx_valid, 0);
        chk("rst_bus_wr", o_bus_wr, 0);
        chk("rst_bus_rd", o_bus_rd, 0);
        chk("rst_err", o_err, 0);
        chk("rst_addr", o_bus_addr, 0);
        chk("rst_wdata", o_bus_wdata, 0);
        chk("rst_tx_data", o_tx_data, 0);
        i_clr_n = 1'b1;
        tick(2);
        i_rx_valid = 1'b1;
        tick(1);
        chk("idle_cs_low_ready", o_rx_ready, 0);
        i_rx_valid = 1'b0;

        wdat[0] = 32'h44332211;
        wdat[1] = 32'h88776655;
        start_frame(); write_frame(8'h10, 8'd2); wait_idle(); end_frame();

        rd_words.push_back(32'hDEADBEEF);
        start_frame(); read_frame(8'h20, 8'd1);
        repeat (4) send_byte(8'hA5);
        wait_idle();
        chk("rd_done_txv", o_tx_valid, 0);
        end_frame();

        wdat[0] = $urandom;
        wdat[1] = $urandom;
        start_frame(); write_frame(8'hFF, 8'd2); wait_idle(); end_frame();

        wdat[0] = 32'hCAFEF00D;
        start_frame(); send_byte(8'h00); write_frame(8'h40, 8'd1); wait_idle(); end_frame();

        e0 = err_cnt;
        t0 = wr_total;
        start_frame();
        send_byte(8'h7E);
        chk("err_pulse", o_err, 1);
        tick(1);
        chk("err_width", o_err, 0);
        repeat (5) send_byte(8'($urandom));
        tick(3);
        chk("bad_err_cnt", err_cnt - e0, 1);
        chk("bad_no_wr", wr_total - t0, 0);
        end_frame();
        wdat[0] = 32'h0A0B0C0D;
        start_frame(); write_frame(8'h50, 8'd1); wait_idle(); end_frame();

        t0 = wr_total;
        start_frame();
        send_byte(8'h01); send_byte(8'h30); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        end_frame();
        tick(3);
        chk("abort_no_wr", wr_total - t0, 0);
        wdat[0] = 32'h12345678;
        start_frame(); write_frame(8'h31, 8'd1); wait_idle(); end_frame();

        wait_cycles = 4;
        wdat[0] = $urandom;
        start_frame(); write_frame(8'h60, 8'd1); wait_idle(); end_frame();
        wdat[0] = $urandom;
        start_frame();
        send_byte(8'h01); send_byte(8'h70); send_byte(8'h02);
        exp_wr.push_back({8'h70, wdat[0]});
        for (int i = 0; i < 4; i++) send_byte(wdat[0][8*i +: 8]);
        i_cs_act = 1'b0;
        tick(10);
        chk("abort_wr_done", exp_wr.size(), 0);
        chk("abort_wr_idle", o_bus_wr, 0);
        wait_cycles = 0;
        tick(2);

        stall_next = 10;
        rd_words.push_back($urandom);
        rd_words.push_back($urandom);
        start_frame(); read_frame(8'h80, 8'd2); wait_idle(); end_frame();
        stall_next = 0;

        rv_delay = 6;
        wait_cycles = 2;
        rv_push = 1'b0;
        rd_words.push_back(32'h0BADF00D);
        start_frame(); read_frame(8'h90, 8'd1);
        i_cs_act = 1'b0;
        tick(12);
        chk("rd_abort_no_tx", o_tx_valid, 0);
        chk("rd_abort_rd", o_bus_rd, 0);
        chk("rd_abort_rd_done", exp_rd.size(), 0);
        rv_push = 1'b1;
        rv_delay = 3;
        wait_cycles = 0;
        tick(2);

        e0 = err_cnt;
        start_frame(); read_frame(8'hA0, 8'd1);
        for (int n = 0; n < 400 && err_cnt == e0; n++) tick(1);
        tick(3);
        chk("tmo_err", err_cnt - e0, 1);
        d = err_cyc - rd_acc_cyc;
        chk("tmo_lat", (d >= RD_TIMEOUT + 1 && d <= RD_TIMEOUT + 3), 1);
        send_byte(8'h01); send_byte(8'h02);
        chk("tmo_drain_txv", o_tx_valid, 0);
        end_frame();
        rd_words.push_back(32'h01020304);
        start_frame(); read_frame(8'hB0, 8'd1); wait_idle(); end_frame();

        for (int w = 0; w < 256; w++) wdat[w] = $urandom;
        t0 = wr_total;
        start_frame(); write_frame(8'h00, 8'h00); wait_idle(); end_frame();
        chk("n256_writes", wr_total - t0, 256);

        tick(5);
        chk("queues_empty", exp_wr.size() + exp_rd.size() + exp_tx.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
